// File: rtl/pc_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller:
// FSM states, next-PC select encodings and vector constants.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_BR  = 2'b01,
    PCS_J   = 2'b10,
    PCS_JR  = 2'b11
  } pcsource_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;
  localparam int          DEF_WAIT_MAX  = 15;

  // Width of a counter that must be able to hold values 0..max.
  function automatic int wait_cnt_width(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential, branch, jump and jump-register targets.
// Purely combinational; all sums wrap modulo 2^32.
module pc_next_calc
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] pc_cnt,
  input  logic [1:0]  pcsource,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic        unused_jr_low;

  assign pc_plus4      = pc_cnt + 32'd4;
  assign unused_jr_low = ^jr_addr[1:0];

  always_comb begin
    next_pc = pc_plus4;
    unique case (pcsource_t'(pcsource))
      PCS_SEQ: next_pc = pc_plus4;
      PCS_BR:  next_pc = pc_plus4 + (branch_offset << 2);
      PCS_J:   next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      PCS_JR:  next_pc = {jr_addr[31:2], 2'b00};
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: boot, fetch handshake with ack timeout,
// hazard stall, and trap entry for interrupts and bus errors.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_BOOT  | one cycle after reset, PC loads RESET_VEC, no request
// ST_FETCH | request outstanding, waiting for imem_ack
// ST_STALL | pipeline hold, PC frozen, no request
// ST_TRAP  | one cycle, PC loads EXC_VEC, no request
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          WAIT_MAX  = DEF_WAIT_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cnt,
  input  logic [1:0]  pcsource,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  input  logic        irq,
  input  logic        imem_ack,
  output logic [31:0] pc_return,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] epc,
  output logic        bus_err
);

  localparam int             WCW       = wait_cnt_width(WAIT_MAX);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           irq_pend;
  logic [31:0]    next_pc;

  logic fetch_live;
  logic ack_take;
  logic take_irq;
  logic timeout_hit;

  pc_next_calc u_next (
    .pc_cnt        (pc_cnt),
    .pcsource      (pcsource),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .jr_addr       (jr_addr),
    .next_pc       (next_pc)
  );

  assign imem_addr = pc_cnt[31:2];

  // Stall outranks both ack and timeout; an ack in the last wait cycle wins.
  assign fetch_live  = (state == ST_FETCH) && !stall;
  assign ack_take    = fetch_live && imem_ack;
  assign take_irq    = ack_take && irq_pend;
  assign timeout_hit = fetch_live && !imem_ack && (wait_cnt == WAIT_LAST);

  // The PC register loads pc_return every cycle, so these must follow
  // pc_cnt and the handshake inputs within the same cycle.
  always_comb begin
    pc_return   = pc_cnt;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      ST_BOOT:  pc_return = RESET_VEC;
      ST_TRAP:  pc_return = EXC_VEC;
      ST_STALL: pc_return = pc_cnt;
      ST_FETCH: begin
        if (!stall) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            instr_valid = 1'b1;
            if (!irq_pend) pc_return = next_pc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      wait_cnt <= '0;
      irq_pend <= 1'b0;
      epc      <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err  <= timeout_hit;
      // A timeout trap leaves a pending interrupt for the next ack.
      irq_pend <= irq | (irq_pend & ~take_irq);
      unique case (state)
        ST_BOOT, ST_TRAP: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_STALL: begin
          wait_cnt <= '0;
          state    <= stall ? ST_STALL : ST_FETCH;
        end
        ST_FETCH: begin
          if (stall) begin
            state    <= ST_STALL;
            wait_cnt <= '0;
          end else if (imem_ack) begin
            wait_cnt <= '0;
            if (irq_pend) begin
              epc   <= next_pc;
              state <= ST_TRAP;
            end
          end else if (timeout_hit) begin
            wait_cnt <= '0;
            epc      <= pc_cnt;
            state    <= ST_TRAP;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a behavioural fetch model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0180;
  localparam int          WM = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cnt = '0;
  logic [1:0]  pcsource = '0;
  logic [31:0] branch_offset = '0;
  logic [25:0] jump_target = '0;
  logic [31:0] jr_addr = '0;
  logic        stall = 1'b0;
  logic        irq = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] pc_return;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        instr_valid;
  logic [31:0] epc;
  logic        bus_err;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_VEC(RV), .EXC_VEC(EV), .WAIT_MAX(WM)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_cnt        (pc_cnt),
    .pcsource      (pcsource),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .jr_addr       (jr_addr),
    .stall         (stall),
    .irq           (irq),
    .imem_ack      (imem_ack),
    .pc_return     (pc_return),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .instr_valid   (instr_valid),
    .epc           (epc),
    .bus_err       (bus_err)
  );

  typedef struct packed {
    logic [31:0] pc_ret;
    logic        req;
    logic        vld;
    logic [29:0] addr;
    logic [31:0] epc;
    logic        berr;
  } exp_t;

  exp_t scb[$];
  int n_tests = 0, n_fail = 0, n_pushed = 0, n_popped = 0;
  logic [31:0] last_pc = RV;

  // Reference model: booleans describing what the controller is doing.
  bit          m_boot = 1'b1, m_trap = 1'b0, m_held = 1'b0;
  bit          m_pend = 1'b0, m_berr = 1'b0;
  int          m_waits = 0;
  logic [31:0] m_epc = '0;

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] src,
                                           input logic [31:0] off, input logic [25:0] tgt,
                                           input logic [31:0] jr);
    logic [31:0] seq;
    seq = pc + 32'd4;
    case (src)
      2'd0:    return seq;
      2'd1:    return seq + off * 32'd4;
      2'd2:    return (seq & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
      default: return jr & ~32'd3;
    endcase
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_trap = 1'b0; m_held = 1'b0;
    m_pend = 1'b0; m_berr = 1'b0; m_waits = 0; m_epc = '0;
  endtask

  // Advance the model over one rising edge using the inputs held across it.
  task automatic model_step();
    bit take, tmo;
    take = 1'b0; tmo = 1'b0;
    if (!rst_n) return;
    if (m_boot || m_trap) begin
      m_boot = 1'b0; m_trap = 1'b0; m_waits = 0;
    end else if (stall) begin
      m_held = 1'b1; m_waits = 0;
    end else if (m_held) begin
      m_held = 1'b0;
    end else if (imem_ack) begin
      m_waits = 0;
      if (m_pend) begin
        take = 1'b1;
        m_epc = ref_next(pc_cnt, pcsource, branch_offset, jump_target, jr_addr);
        m_trap = 1'b1;
      end
    end else if (m_waits + 1 >= WM) begin
      tmo = 1'b1; m_waits = 0; m_epc = pc_cnt; m_trap = 1'b1;
    end else begin
      m_waits++;
    end
    m_berr = tmo;
    m_pend = irq || (m_pend && !take);
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.addr = pc_cnt[31:2];
    e.epc = m_epc;
    e.berr = m_berr;
    e.req = 1'b0;
    e.vld = 1'b0;
    e.pc_ret = pc_cnt;
    if (!rst_n || m_boot) e.pc_ret = RV;
    else if (m_trap) e.pc_ret = EV;
    else if (!m_held && !stall) begin
      e.req = 1'b1;
      if (imem_ack) begin
        e.vld = 1'b1;
        if (!m_pend) e.pc_ret = ref_next(pc_cnt, pcsource, branch_offset, jump_target, jr_addr);
      end
    end
    return e;
  endfunction

  task automatic cycle(input bit r, input logic [31:0] pc, input logic [1:0] src,
                       input bit st, input bit iq, input bit ak,
                       input logic [31:0] off = 32'd0, input logic [25:0] tgt = 26'd0,
                       input logic [31:0] jr = 32'd0);
    exp_t e;
    @(posedge clk);
    #1;
    model_step();
    rst_n = r; pc_cnt = pc; pcsource = src; stall = st; irq = iq; imem_ack = ak;
    branch_offset = off; jump_target = tgt; jr_addr = jr;
    if (!r) model_reset();
    e = model_expect();
    last_pc = e.pc_ret;
    scb.push_back(e);
    n_pushed++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        n_popped++;
        chk("pc_return",   pc_return,          e.pc_ret);
        chk("imem_req",    32'(imem_req),      32'(e.req));
        chk("instr_valid", 32'(instr_valid),   32'(e.vld));
        chk("imem_addr",   32'(imem_addr),     32'(e.addr));
        chk("epc",         epc,                e.epc);
        chk("bus_err",     32'(bus_err),       32'(e.berr));
      end
    end
  end

  initial begin : stimulus
    // Reset, then sequential fetch with ack tied high.
    repeat (2) cycle(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    repeat (6) cycle(1'b1, last_pc, 2'd0, 1'b0, 1'b0, 1'b1);
    // Branch back by two words, then a J-type jump.
    cycle(1'b1, 32'h100, 2'd1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    cycle(1'b1, 32'h100, 2'd2, 1'b0, 1'b0, 1'b1, 32'd0, 26'h40);
    cycle(1'b1, 32'h100, 2'd3, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 32'h1234_5677);
    // Three-cycle stall, release cycle, then the refetch.
    repeat (3) cycle(1'b1, 32'h20, 2'd0, 1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 32'h20, 2'd0, 1'b0, 1'b0, 1'b1);
    // Interrupt pulse during a wait, taken at the next ack.
    cycle(1'b1, 32'h40, 2'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h40, 2'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, last_pc, 2'd0, 1'b0, 1'b0, 1'b1);
    // Full timeout.
    repeat (WM) cycle(1'b1, 32'h80, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, last_pc, 2'd0, 1'b0, 1'b0, 1'b1);
    // Ack arriving in the last wait cycle beats the timeout.
    repeat (WM - 1) cycle(1'b1, 32'h80, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, last_pc, 2'd0, 1'b0, 1'b0, 1'b1);
    // Timeout and irq together: one trap, interrupt still pending after.
    repeat (WM - 1) cycle(1'b1, 32'h80, 2'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h80, 2'd0, 1'b0, 1'b1, 1'b0);
    repeat (4) cycle(1'b1, last_pc, 2'd0, 1'b0, 1'b0, 1'b1);
    // Reset asserted inside the trap cycle.
    repeat (WM) cycle(1'b1, 32'h80, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, last_pc, 2'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, last_pc, 2'd0, 1'b0, 1'b0, 1'b1);

    // Random traffic: mostly acks, then a slow memory that times out often.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 2000; i++) begin
        bit r, st, iq, ak;
        logic [31:0] pc_v;
        r  = ($urandom_range(0, 299) != 0);
        st = ($urandom_range(0, 99) < 12);
        iq = ($urandom_range(0, 99) < 4);
        ak = ($urandom_range(0, 99) < ((phase == 0) ? 60 : 4));
        pc_v = ($urandom_range(0, 3) != 0) ? last_pc : $urandom();
        cycle(r, pc_v, 2'($urandom_range(0, 3)), st, iq, ak,
              $urandom(), 26'($urandom()), $urandom());
      end
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(n_popped), 32'(n_pushed));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
